// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath: default pixel width and
// the signed-max helper used by pooling stages.
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 20;

    typedef logic signed [CNN_DATA_WIDTH-1:0] pixel_t;

    // Two's complement max; on a tie either operand is the same value.
    function automatic pixel_t smax(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line buffer for 2x2 pooling: holds the horizontal maxima of the
// even row until the odd row below consumes them. Not reset.
module pool_line_buffer #(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 14,
    parameter int AW         = 4
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [AW-1:0]                waddr_i,
    input  logic signed [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]                raddr_i,
    output logic signed [DATA_WIDTH-1:0] rdata_o
);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max-pooling stage fed by the ReLU output in
// raster order; emits one pooled pixel per window, also in raster order.
module max_pool_2x2
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         frame_done
);

    // Stream semantics: no ready on either side. A pixel is accepted on every
    // rising edge with in_valid=1 and clear=0; out_valid is a one-cycle strobe.

    localparam int DEPTH = IMG_WIDTH / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    if ((IMG_WIDTH < 2) || ((IMG_WIDTH % 2) != 0)) begin : g_bad_width
        $fatal(1, "max_pool_2x2: IMG_WIDTH must be even and >= 2");
    end
    if ((IMG_HEIGHT < 2) || ((IMG_HEIGHT % 2) != 0)) begin : g_bad_height
        $fatal(1, "max_pool_2x2: IMG_HEIGHT must be even and >= 2");
    end
    if (DATA_WIDTH != CNN_DATA_WIDTH) begin : g_bad_data_width
        $fatal(1, "max_pool_2x2: DATA_WIDTH must match cnn_pkg pixel width");
    end

    logic [COL_W-1:0]              col_q, col_d;
    logic [ROW_W-1:0]              row_q, row_d;
    logic signed [DATA_WIDTH-1:0]  pair_q, pair_d;
    logic                          out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                          frame_done_q, frame_done_d;

    logic                          col_last, row_last;
    logic signed [DATA_WIDTH-1:0]  hmax;
    logic signed [DATA_WIDTH-1:0]  lb_rdata;
    logic [AW-1:0]                 lb_addr;
    logic                          lb_we;

    assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
    assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));
    assign hmax     = smax(pair_q, in_data);
    assign lb_addr  = AW'(col_q >> 1);

    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (hmax),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        // line_buf and pair_q are always rewritten before being read, so a
        // restart only needs the counters and the output registers.
        if (clear) begin
            col_d      = '0;
            row_d      = '0;
            out_data_d = '0;
        end else if (in_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_q[0]) begin
                pair_d = in_data;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                out_data_d   = smax(lb_rdata, hmax);
                frame_done_d = row_last && col_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2 on a 4x4 frame: a frame-array model
// computes each window maximum from the pixels actually accepted.
module tb_max_pool_2x2;

    localparam int DW   = 20;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pixels of the current frame by raster index.
    int                   frame_m [NPIX];
    int                   idx_m = 0;
    logic signed [DW-1:0] exp_data_m = '0;
    logic [DW-1:0]        exp_q [$];

    max_pool_2x2 #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one cycle and returns what the outputs must be just after the edge.
    task automatic step(input logic v, input logic signed [DW-1:0] d, input logic c,
                        output logic exp_v, output logic exp_fd,
                        output logic signed [DW-1:0] exp_d);
        int r, cc, m;
        in_valid = v;
        in_data  = d;
        clear    = c;
        exp_v    = 1'b0;
        exp_fd   = 1'b0;
        if (c) begin
            idx_m      = 0;
            exp_data_m = '0;
        end else if (v) begin
            frame_m[idx_m] = int'(d);
            r  = idx_m / W;
            cc = idx_m % W;
            if ((r % 2 == 1) && (cc % 2 == 1)) begin
                m = frame_m[idx_m];
                if (frame_m[idx_m - 1] > m)     m = frame_m[idx_m - 1];
                if (frame_m[idx_m - W] > m)     m = frame_m[idx_m - W];
                if (frame_m[idx_m - W - 1] > m) m = frame_m[idx_m - W - 1];
                exp_v      = 1'b1;
                exp_data_m = DW'(m);
                exp_fd     = (idx_m == NPIX - 1);
            end
            idx_m = (idx_m + 1) % NPIX;
        end
        exp_d = exp_data_m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic ev, efd;
        logic signed [DW-1:0] ed;
        #2;
        n_checks++;
        if ({out_valid, frame_done, out_data} !== {1'b0, 1'b0, {DW{1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_state: got v=%b fd=%b d=%0d, want 0 0 0", out_valid, frame_done, out_data);
        end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, '0, 1'b0, ev, efd, ed);
        n_checks++;
        if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
            n_errors++;
            $display("FAIL reset_idle: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", out_valid, frame_done, out_data, ev, efd, ed);
        end
    endtask

    task automatic test_ramp();
        logic ev, efd;
        logic signed [DW-1:0] ed;
        exp_q = '{20'd5, 20'd7, 20'd13, 20'd15};
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, DW'(i), 1'b0, ev, efd, ed);
            n_checks++;
            if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
                n_errors++;
                $display("FAIL ramp px%0d: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", i, out_valid, frame_done, out_data, ev, efd, ed);
            end
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL ramp_extra px%0d: got output %0d, want none", i, out_data);
                end else if (out_data !== exp_q.pop_front()) begin
                    n_errors++;
                    $display("FAIL ramp_value px%0d: got %0d, want one of 5,7,13,15 in order", i, out_data);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL ramp_count: got %0d outputs, want 4", 4 - exp_q.size());
        end
    endtask

    task automatic test_gaps();
        logic ev, efd;
        logic signed [DW-1:0] ed;
        int gap;
        exp_q = '{20'd5, 20'd7, 20'd13, 20'd15};
        for (int i = 0; i < NPIX; i++) begin
            gap = (i % 2 == 0) ? 1 : $urandom_range(0, 5);
            for (int g = 0; g <= gap; g++) begin
                if (g == gap) step(1'b1, DW'(i), 1'b0, ev, efd, ed);
                else          step(1'b0, DW'($urandom), 1'b0, ev, efd, ed);
                n_checks++;
                if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
                    n_errors++;
                    $display("FAIL gaps px%0d: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", i, out_valid, frame_done, out_data, ev, efd, ed);
                end
                if (out_valid) begin
                    n_checks++;
                    if ((exp_q.size() == 0) || (out_data !== exp_q.pop_front())) begin
                        n_errors++;
                        $display("FAIL gaps_value px%0d: got %0d, want next of 5,7,13,15", i, out_data);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL gaps_count: got %0d outputs, want 4", 4 - exp_q.size());
        end
    endtask

    task automatic test_signed();
        logic ev, efd;
        logic signed [DW-1:0] ed;
        logic signed [DW-1:0] px [NPIX];
        for (int i = 0; i < NPIX; i++) px[i] = DW'($urandom);
        px[0] = -20'sd3;  px[1] = -20'sd8;  px[4] = -20'sd1;  px[5] = -20'sd20;
        px[2] = 20'h7FFFF; px[3] = 20'h7FFFF; px[6] = 20'h7FFFF; px[7] = 20'h7FFFF;
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, px[i], 1'b0, ev, efd, ed);
            n_checks++;
            if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
                n_errors++;
                $display("FAIL signed px%0d: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", i, out_valid, frame_done, out_data, ev, efd, ed);
            end
            if (i == 5) begin
                n_checks++;
                if (out_data !== -20'sd1) begin
                    n_errors++;
                    $display("FAIL signed_neg: got %0d, want -1", out_data);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (out_data !== 20'h7FFFF) begin
                    n_errors++;
                    $display("FAIL signed_max: got %h, want 7ffff", out_data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ev, efd;
        logic signed [DW-1:0] ed;
        int n_out = 0;
        int n_fd = 0;
        for (int i = 0; i < 2 * NPIX; i++) begin
            step(1'b1, DW'($urandom), 1'b0, ev, efd, ed);
            n_checks++;
            if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
                n_errors++;
                $display("FAIL b2b px%0d: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", i, out_valid, frame_done, out_data, ev, efd, ed);
            end
            if (out_valid)  n_out++;
            if (frame_done) n_fd++;
        end
        n_checks++;
        if ((n_out != 8) || (n_fd != 2)) begin
            n_errors++;
            $display("FAIL b2b_count: got outputs=%0d frame_done=%0d, want 8 and 2", n_out, n_fd);
        end
    endtask

    task automatic test_clear();
        logic ev, efd;
        logic signed [DW-1:0] ed;
        int n_out = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, DW'($urandom), 1'b0, ev, efd, ed);
            n_checks++;
            if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
                n_errors++;
                $display("FAIL clear_pre px%0d: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", i, out_valid, frame_done, out_data, ev, efd, ed);
            end
        end
        step(1'b1, DW'($urandom), 1'b1, ev, efd, ed);
        n_checks++;
        if ({out_valid, frame_done, out_data} !== {1'b0, 1'b0, {DW{1'b0}}}) begin
            n_errors++;
            $display("FAIL clear_edge: got v=%b fd=%b d=%0d, want 0 0 0", out_valid, frame_done, out_data);
        end
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, DW'($urandom), 1'b0, ev, efd, ed);
            n_checks++;
            if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
                n_errors++;
                $display("FAIL clear_post px%0d: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", i, out_valid, frame_done, out_data, ev, efd, ed);
            end
            if (out_valid) n_out++;
        end
        n_checks++;
        if (n_out != 4) begin
            n_errors++;
            $display("FAIL clear_count: got %0d outputs, want 4", n_out);
        end
    endtask

    task automatic test_async_reset();
        logic ev, efd;
        logic signed [DW-1:0] ed;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, DW'($urandom_range(1, 1000)), 1'b0, ev, efd, ed);
            n_checks++;
            if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
                n_errors++;
                $display("FAIL arst_pre px%0d: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", i, out_valid, frame_done, out_data, ev, efd, ed);
            end
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, frame_done, out_data} !== {1'b0, 1'b0, {DW{1'b0}}}) begin
            n_errors++;
            $display("FAIL arst_now: got v=%b fd=%b d=%0d, want 0 0 0", out_valid, frame_done, out_data);
        end
        idx_m      = 0;
        exp_data_m = '0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            step(1'b1, DW'($urandom), 1'b0, ev, efd, ed);
            n_checks++;
            if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
                n_errors++;
                $display("FAIL arst_post px%0d: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", i, out_valid, frame_done, out_data, ev, efd, ed);
            end
        end
    endtask

    task automatic test_random();
        logic ev, efd;
        logic signed [DW-1:0] ed;
        logic v;
        for (int i = 0; i < 6 * NPIX; i++) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, DW'($urandom), 1'b0, ev, efd, ed);
            n_checks++;
            if ({out_valid, frame_done, out_data} !== {ev, efd, ed}) begin
                n_errors++;
                $display("FAIL random cyc%0d: got v=%b fd=%b d=%0d, want v=%b fd=%b d=%0d", i, out_valid, frame_done, out_data, ev, efd, ed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_signed();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
